// File: rtl/event_fifo_irq.sv
// Event word FIFO between pixel-event capture and SPI readout, with occupancy
// reporting, a hysteretic threshold interrupt and a sticky overflow flag.
module event_fifo_irq #(
  parameter int DATA_WIDTH = 16,
  parameter int AWIDTH     = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_rst_n,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [AWIDTH-1:0]     fifo_numel,
  input  logic [AWIDTH-1:0]     irq_assert_thresh,
  input  logic [AWIDTH-1:0]     irq_deassert_thresh,
  output logic                  irq,
  output logic                  overflow,
  input  logic                  ovf_clr
);

  localparam int DEPTH = 1 << AWIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AWIDTH-1:0]     wptr;
  logic [AWIDTH-1:0]     rptr;
  logic [AWIDTH-1:0]     wptr_inc;
  logic                  srst;
  logic                  full;
  logic                  empty;
  logic                  do_wr;
  logic                  do_rd;

  // Hard reset and regfile soft reset have identical effect.
  assign srst     = rst || !fifo_rst_n;
  assign wptr_inc = wptr + AWIDTH'(1);
  assign full     = (wptr_inc == rptr);
  assign empty    = (wptr == rptr);
  assign wr_ready = !full;
  assign do_wr    = wr_valid && !full;
  assign do_rd    = fifo_rd_en && !empty;

  // NOTE: storage has no reset so it maps onto plain RAM; only the pointers
  // decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_wr && !srst) begin
      mem[wptr] <= wr_data;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // sees the pre-edge full/empty and occupancy values.
  always_ff @(posedge clk) begin
    if (srst) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_numel <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      irq        <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      rd_valid <= do_rd;

      if (do_wr) begin
        wptr <= wptr_inc;
      end

      if (do_rd) begin
        rd_data <= mem[rptr];
        rptr    <= rptr + AWIDTH'(1);
      end

      if (do_wr && !do_rd) begin
        fifo_numel <= fifo_numel + AWIDTH'(1);
      end else if (do_rd && !do_wr) begin
        fifo_numel <= fifo_numel - AWIDTH'(1);
      end

      // Assert threshold wins when the two thresholds overlap.
      if (fifo_numel >= irq_assert_thresh) begin
        irq <= 1'b1;
      end else if (fifo_numel <= irq_deassert_thresh) begin
        irq <= 1'b0;
      end

      if (wr_valid && full) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_event_fifo_irq.sv
// Bench for event_fifo_irq at AWIDTH=3: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_event_fifo_irq;

  localparam int AW  = 3;
  localparam int DW  = 16;
  localparam int CAP = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_rst_n;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          fifo_rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [AW-1:0] fifo_numel;
  logic [AW-1:0] irq_assert_thresh;
  logic [AW-1:0] irq_deassert_thresh;
  logic          irq;
  logic          overflow;
  logic          ovf_clr;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DW-1:0] q [$];
  logic          m_irq;
  logic          m_ovf;
  logic          m_rv;
  logic [DW-1:0] m_rd;

  event_fifo_irq #(.DATA_WIDTH(DW), .AWIDTH(AW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .fifo_rst_n          (fifo_rst_n),
    .wr_valid            (wr_valid),
    .wr_data             (wr_data),
    .wr_ready            (wr_ready),
    .fifo_rd_en          (fifo_rd_en),
    .rd_data             (rd_data),
    .rd_valid            (rd_valid),
    .fifo_numel          (fifo_numel),
    .irq_assert_thresh   (irq_assert_thresh),
    .irq_deassert_thresh (irq_deassert_thresh),
    .irq                 (irq),
    .overflow            (overflow),
    .ovf_clr             (ovf_clr)
  );

  always #5 clk = ~clk;

  // Drive one cycle, advance the model across the edge, then settle.
  task automatic tick(input logic wv, input logic [DW-1:0] wd, input logic re);
    int  n;
    logic pre_full, pre_empty;
    wr_valid   = wv;
    wr_data    = wd;
    fifo_rd_en = re;
    @(posedge clk);
    if (rst || !fifo_rst_n) begin
      q.delete();
      m_irq = 1'b0;
      m_ovf = 1'b0;
      m_rv  = 1'b0;
      m_rd  = '0;
    end else begin
      n         = q.size();
      pre_full  = (n == CAP);
      pre_empty = (n == 0);
      if (n >= int'(irq_assert_thresh)) m_irq = 1'b1;
      else if (n <= int'(irq_deassert_thresh)) m_irq = 1'b0;
      m_rv = 1'b0;
      if (re && !pre_empty) begin
        m_rd = q.pop_front();
        m_rv = 1'b1;
      end
      if (wv && !pre_full) q.push_back(wd);
      if (wv && pre_full) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
    end
    #1;
    wr_valid   = 1'b0;
    fifo_rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(1'b1, 16'h1234, 1'b1);
    rst = 1'b0;
    total++;
    if ({fifo_numel, wr_ready, rd_valid, rd_data, irq, overflow} !== {3'd0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state got numel=%0d rdy=%b rv=%b rd=%h irq=%b ovf=%b exp 0 1 0 0000 0 0",
               fifo_numel, wr_ready, rd_valid, rd_data, irq, overflow);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      tick(1'b1, DW'(i), 1'b0);
      if (i == 7) begin
        total++;
        if (wr_ready !== 1'b0 || fifo_numel !== 3'd7) begin
          bad++;
          $display("FAIL fill_full got rdy=%b numel=%0d exp rdy=0 numel=7", wr_ready, fifo_numel);
        end
      end
    end
    total++;
    if (overflow !== 1'b1 || fifo_numel !== 3'd7) begin
      bad++;
      $display("FAIL fill_drop got ovf=%b numel=%0d exp ovf=1 numel=7", overflow, fifo_numel);
    end
    for (int i = 1; i <= 7; i++) begin
      tick(1'b0, '0, 1'b1);
      total++;
      if (rd_valid !== 1'b1 || rd_data !== DW'(i)) begin
        bad++;
        $display("FAIL fill_pop%0d got rv=%b rd=%h exp rv=1 rd=%h", i, rd_valid, rd_data, DW'(i));
      end
    end
    total++;
    if (fifo_numel !== 3'd0 || overflow !== 1'b1) begin
      bad++;
      $display("FAIL fill_drained got numel=%0d ovf=%b exp numel=0 ovf=1", fifo_numel, overflow);
    end
    ovf_clr = 1'b1;
    tick(1'b0, '0, 1'b0);
    ovf_clr = 1'b0;
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clr got ovf=%b exp 0", overflow);
    end
  endtask

  task automatic test_irq_hyst();
    irq_assert_thresh   = 3'd5;
    irq_deassert_thresh = 3'd2;
    tick(1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b1, DW'(16'h50 + i), 1'b0);
    total++;
    if (fifo_numel !== 3'd5 || irq !== 1'b0) begin
      bad++;
      $display("FAIL irq_lag got numel=%0d irq=%b exp numel=5 irq=0", fifo_numel, irq);
    end
    tick(1'b0, '0, 1'b0);
    total++;
    if (irq !== 1'b1) begin
      bad++;
      $display("FAIL irq_rise got irq=%b exp 1", irq);
    end
    tick(1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b0);
    total++;
    if (fifo_numel !== 3'd3 || irq !== 1'b1) begin
      bad++;
      $display("FAIL irq_hold_hi got numel=%0d irq=%b exp numel=3 irq=1", fifo_numel, irq);
    end
    tick(1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b0);
    total++;
    if (fifo_numel !== 3'd2 || irq !== 1'b0) begin
      bad++;
      $display("FAIL irq_fall got numel=%0d irq=%b exp numel=2 irq=0", fifo_numel, irq);
    end
    tick(1'b1, 16'h60, 1'b0);
    tick(1'b1, 16'h61, 1'b0);
    tick(1'b0, '0, 1'b0);
    total++;
    if (fifo_numel !== 3'd4 || irq !== 1'b0) begin
      bad++;
      $display("FAIL irq_hold_lo got numel=%0d irq=%b exp numel=4 irq=0", fifo_numel, irq);
    end
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] oldest;
    tick(1'b0, '0, 1'b1);
    oldest = q[0];
    tick(1'b1, 16'h0AAA, 1'b1);
    total++;
    if (fifo_numel !== 3'd3 || rd_valid !== 1'b1 || rd_data !== oldest) begin
      bad++;
      $display("FAIL simul_mid got numel=%0d rv=%b rd=%h exp numel=3 rv=1 rd=%h",
               fifo_numel, rd_valid, rd_data, oldest);
    end
    for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b1);
    tick(1'b1, 16'h0BBB, 1'b1);
    total++;
    if (fifo_numel !== 3'd1 || rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL simul_empty got numel=%0d rv=%b exp numel=1 rv=0", fifo_numel, rd_valid);
    end
    for (int i = 0; i < 6; i++) tick(1'b1, DW'(16'h0C00 + i), 1'b0);
    tick(1'b1, 16'h0CCC, 1'b1);
    total++;
    if (fifo_numel !== 3'd6 || overflow !== 1'b1 || rd_data !== 16'h0BBB) begin
      bad++;
      $display("FAIL simul_full got numel=%0d ovf=%b rd=%h exp numel=6 ovf=1 rd=0bbb",
               fifo_numel, overflow, rd_data);
    end
  endtask

  task automatic test_soft_reset();
    tick(1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b1);
    total++;
    if (fifo_numel !== 3'd4 || irq !== 1'b1) begin
      bad++;
      $display("FAIL srst_pre got numel=%0d irq=%b exp numel=4 irq=1", fifo_numel, irq);
    end
    fifo_rst_n = 1'b0;
    tick(1'b1, 16'hDEAD, 1'b1);
    fifo_rst_n = 1'b1;
    total++;
    if ({fifo_numel, irq, overflow, rd_valid, rd_data} !== {3'd0, 1'b0, 1'b0, 1'b0, 16'h0}) begin
      bad++;
      $display("FAIL srst_clear got numel=%0d irq=%b ovf=%b rv=%b rd=%h exp 0 0 0 0 0000",
               fifo_numel, irq, overflow, rd_valid, rd_data);
    end
    tick(1'b1, 16'hBEEF, 1'b0);
    tick(1'b0, '0, 1'b1);
    total++;
    if (rd_valid !== 1'b1 || rd_data !== 16'hBEEF) begin
      bad++;
      $display("FAIL srst_beef got rv=%b rd=%h exp rv=1 rd=beef", rd_valid, rd_data);
    end
  endtask

  task automatic test_wrap();
    int errs = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, DW'(16'h0100 + i), 1'b0);
      if (fifo_numel > 3'd1) errs++;
      tick(1'b0, '0, 1'b1);
      if (fifo_numel > 3'd1 || rd_valid !== 1'b1 || rd_data !== DW'(16'h0100 + i)) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL wrap got errors=%0d exp 0", errs);
    end
  endtask

  task automatic test_degenerate();
    int errs = 0;
    irq_assert_thresh   = 3'd0;
    irq_deassert_thresh = 3'd0;
    rst = 1'b1;
    tick(1'b0, '0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, '0, 1'b0);
      if (irq !== 1'b1) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL irq_zero_thresh got low_cycles=%0d exp 0", errs);
    end
    tick(1'b1, 16'h00AA, 1'b0);
    tick(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, '0, 1'b1);
      total++;
      if (rd_valid !== 1'b0 || rd_data !== 16'h00AA) begin
        bad++;
        $display("FAIL empty_read got rv=%b rd=%h exp rv=0 rd=00aa", rd_valid, rd_data);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        irq_assert_thresh   = AW'($urandom_range(0, CAP));
        irq_deassert_thresh = AW'($urandom_range(0, CAP));
      end
      ovf_clr    = ($urandom_range(0, 7) == 0);
      fifo_rst_n = ($urandom_range(0, 99) != 0);
      tick($urandom_range(0, 2) != 0, DW'($urandom), $urandom_range(0, 1) == 1);
      ovf_clr    = 1'b0;
      fifo_rst_n = 1'b1;
      total++;
      if ({fifo_numel, wr_ready, rd_valid, irq, overflow} !==
          {AW'(q.size()), q.size() != CAP, m_rv, m_irq, m_ovf} || rd_data !== m_rd) begin
        bad++;
        $display("FAIL random_c%0d got numel=%0d rdy=%b rv=%b rd=%h irq=%b ovf=%b exp numel=%0d rdy=%b rv=%b rd=%h irq=%b ovf=%b",
                 c, fifo_numel, wr_ready, rd_valid, rd_data, irq, overflow,
                 q.size(), q.size() != CAP, m_rv, m_rd, m_irq, m_ovf);
      end
    end
  endtask

  initial begin
    rst                 = 1'b1;
    fifo_rst_n          = 1'b1;
    wr_valid            = 1'b0;
    wr_data             = '0;
    fifo_rd_en          = 1'b0;
    ovf_clr             = 1'b0;
    irq_assert_thresh   = 3'd7;
    irq_deassert_thresh = 3'd0;
    test_reset();
    test_fill();
    test_irq_hyst();
    test_simultaneous();
    test_soft_reset();
    test_wrap();
    test_degenerate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
